div_err_accumulator: RTL and testbench
======================================

Name: div_err_accumulator

Overview:
- Sequential error-statistics stage directly downstream of the 8-bit approximate array divider (16-bit dividend, 8-bit divisor, 8-bit quotient/remainder).
- Consumes, per sample, the approximate quotient/remainder together with the exact quotient/remainder from a golden divider.
- Accumulates over a power-of-two window: sum of squared quotient error, mean squared error, maximum absolute error, and mismatch counts.
- Drives the area/MSE characterisation flow of approximate divider cells.

Parameters:
- Q_W, 8, quotient/remainder width
- SSE_W, 32, squared-error accumulator width
- CNT_W, 16, sample/mismatch counter width
- MAX_LOG2, 15, largest permitted win_log2

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  begin new measurement window (pulse)
- win_log2  input  4  window size N = 2**win_log2; sampled at accepted start
- in_valid  input  1  sample valid
- in_ready  output  1  stage accepts sample
- q_apx  input  Q_W  approximate quotient
- q_ext  input  Q_W  exact quotient
- r_apx  input  Q_W  approximate remainder
- r_ext  input  Q_W  exact remainder
- busy  output  1  window in progress (ACCUM or DRAIN)
- done  output  1  one-cycle pulse, results valid
- sse  output  SSE_W  saturating sum of (q_apx-q_ext)^2
- mse  output  SSE_W  sse >> win_log2 (latched N)
- max_err  output  Q_W  maximum |q_apx-q_ext|
- q_mis_cnt  output  CNT_W  samples with q_apx != q_ext
- r_mis_cnt  output  CNT_W  samples with r_apx != r_ext
- sat  output  1  sse saturated during window

Behaviour:
- One clock domain. Reset is synchronous, active-low (rst_n sampled on the rising edge of clk). Reset forces the FSM to IDLE and clears every output and internal register to 0, including in_ready, busy, done and sat. A mid-window reset abandons the window; no done pulse follows.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE: start=1 moves to ACCUM. On that transition: latch N from win_log2, clamping any value > MAX_LOG2 to MAX_LOG2; clear all statistics and sat; zero the accepted-sample count.
- ACCUM: in_ready = 1 while accepted < N. A sample is accepted when in_valid & in_ready. After the N-th acceptance, in_ready drops the next cycle and the FSM moves to DRAIN.
- DRAIN: exactly 2 cycles (pipeline depth); in_ready = 0; then move to DONE.
- DONE: lasts one cycle. done = 1, then return to IDLE. All outputs hold until the next accepted start.
- start in ACCUM or DRAIN is ignored. start in DONE is ignored; it is honoured from IDLE on the next cycle.
- busy = 1 in ACCUM and DRAIN.
- Pipeline stage 1, registered on acceptance:
  - signed 9-bit diff = q_apx - q_ext
  - abs_err (8 bit)
  - q_mis = (q_apx != q_ext)
  - r_mis = (r_apx != r_ext)
  - valid bit
- Pipeline stage 2: sq = abs_err*abs_err (16 bit), added into sse, which saturates at all-ones and sets sat. Update max_err if abs_err > max_err. Increment each mismatch counter if its flag is set; counters saturate at all-ones.
- mse is updated combinationally from sse and the latched N. It is meaningful when done = 1.
- Statistics reflect exactly N samples. No sample is lost or double-counted under arbitrary in_valid gaps.

Decomposition:
- Shared package div_pkg holds:
  - typedef for the FSM state enum
  - Q_W/CNT_W defaults
  - DRAIN_CYCLES = 2
  - function sat_add(a,b)
- One sub-module div_err_sq, the stage-1/2 datapath: abs difference, square, and flag register. The FSM and accumulators live in the top.

Test Plan:
- Reset mid-window: start, win_log2=4, 5 samples, then rst_n=0 for one cycle -> all outputs 0, state IDLE, no done pulse.
- Exact match: win_log2=3, 8 samples with q_apx=q_ext=0x2A -> done after last accept + 3 cycles; sse=0, mse=0, max_err=0, both mismatch counts 0.
- Mixed errors: win_log2=2, quotient pairs (10,7), (7,10), (0,0), (255,0) -> sse=9+9+0+65025=65043, mse=16260, max_err=255, q_mis_cnt=3.
- Valid gaps and start during ACCUM: in_valid toggles randomly, start pulses mid-window, win_log2=1 -> exactly 2 samples counted; extra start ignored; in_ready=0 after the 2nd accept.
- Saturation: SSE_W=16 build, win_log2=2, four samples with error 255 -> sse=0xFFFF, sat=1.
- Clamp and remainder: win_log2=15 with MAX_LOG2=15, r_apx != r_ext on every 4th sample -> after 32768 samples, r_mis_cnt=8192 and done pulses once.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types, defaults and saturating-arithmetic helpers for the
// approximate-divider error-statistics stage.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned Q_W_DEF      = 8;
  localparam int unsigned CNT_W_DEF    = 16;
  localparam int unsigned DRAIN_CYCLES = 2;

  function automatic logic [63:0] sat_lim(input int unsigned w);
    if (w >= 64) begin
      sat_lim = {64{1'b1}};
    end else begin
      sat_lim = (64'd1 << w) - 64'd1;
    end
  endfunction

  // Unsigned a+b clamped to the all-ones value of a w-bit field.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [63:0] lim;
    lim = sat_lim(w);
    if ((b > lim) || (a > (lim - b))) begin
      sat_add = lim;
    end else begin
      sat_add = a + b;
    end
  endfunction

  function automatic logic sat_ovf(input logic [63:0] a, input logic [63:0] b,
                                   input int unsigned w);
    logic [63:0] lim;
    lim = sat_lim(w);
    sat_ovf = (b > lim) || (a > (lim - b));
  endfunction

endpackage

// File: rtl/div_err_sq.sv
// Two-stage error datapath: stage 1 registers the quotient error magnitude and
// mismatch flags of an accepted sample, stage 2 presents its square.
module div_err_sq
  import div_pkg::*;
#(
  parameter int Q_W = Q_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [Q_W-1:0]     q_apx,
  input  logic [Q_W-1:0]     q_ext,
  input  logic [Q_W-1:0]     r_apx,
  input  logic [Q_W-1:0]     r_ext,
  output logic               vld,
  output logic [Q_W-1:0]     abs_err,
  output logic [2*Q_W-1:0]   sq,
  output logic               q_mis,
  output logic               r_mis
);

  logic [Q_W:0]   diff_s;
  logic [Q_W-1:0] abs_s;
  logic           vld_r;
  logic [Q_W-1:0] abs_r;
  logic           q_mis_r;
  logic           r_mis_r;

  // Sign bit of the 9-bit difference selects which subtraction gives |error|.
  assign diff_s = {1'b0, q_apx} - {1'b0, q_ext};
  assign abs_s  = diff_s[Q_W] ? (q_ext - q_apx) : diff_s[Q_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_r   <= 1'b0;
      abs_r   <= {Q_W{1'b0}};
      q_mis_r <= 1'b0;
      r_mis_r <= 1'b0;
    end else begin
      vld_r <= load;
      if (load) begin
        abs_r   <= abs_s;
        q_mis_r <= (q_apx != q_ext);
        r_mis_r <= (r_apx != r_ext);
      end
    end
  end

  assign vld     = vld_r;
  assign abs_err = abs_r;
  assign sq      = (2*Q_W)'(abs_r) * (2*Q_W)'(abs_r);
  assign q_mis   = q_mis_r;
  assign r_mis   = r_mis_r;

endmodule

// File: rtl/div_err_accumulator.sv
// Windowed error statistics (SSE, MSE, max |error|, mismatch counts) for an
// approximate divider measured against a golden reference.
module div_err_accumulator
  import div_pkg::*;
#(
  parameter int Q_W      = Q_W_DEF,
  parameter int SSE_W    = 32,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MAX_LOG2 = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        win_log2,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [Q_W-1:0]    q_apx,
  input  logic [Q_W-1:0]    q_ext,
  input  logic [Q_W-1:0]    r_apx,
  input  logic [Q_W-1:0]    r_ext,
  output logic              busy,
  output logic              done,
  output logic [SSE_W-1:0]  sse,
  output logic [SSE_W-1:0]  mse,
  output logic [Q_W-1:0]    max_err,
  output logic [CNT_W-1:0]  q_mis_cnt,
  output logic [CNT_W-1:0]  r_mis_cnt,
  output logic              sat
);

  localparam int CW = MAX_LOG2 + 1;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t          state_r, state_nxt;
  logic [3:0]      n_log2_r, log2_clamped_s;
  logic [CW-1:0]   acc_cnt_r, n_last_s;
  logic [1:0]      drain_cnt_r;
  logic            accept_s, last_accept_s, start_ok_s;
  logic            in_ready_r, busy_r, done_r;

  logic            s_vld, s_q_mis, s_r_mis;
  logic [Q_W-1:0]  s_abs;
  logic [2*Q_W-1:0] s_sq;

  logic [SSE_W-1:0] sse_r;
  logic             sat_r;
  logic [Q_W-1:0]   max_err_r;
  logic [CNT_W-1:0] q_mis_cnt_r, r_mis_cnt_r;

  assign log2_clamped_s = (win_log2 > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : win_log2;
  assign n_last_s       = (CNT_ONE << n_log2_r) - CNT_ONE;
  assign accept_s       = in_valid & in_ready_r;
  assign last_accept_s  = accept_s & (acc_cnt_r == n_last_s);
  assign start_ok_s     = (state_r == ST_IDLE) & start;

  div_err_sq #(.Q_W(Q_W)) u_err_sq (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept_s),
    .q_apx   (q_apx),
    .q_ext   (q_ext),
    .r_apx   (r_apx),
    .r_ext   (r_ext),
    .vld     (s_vld),
    .abs_err (s_abs),
    .sq      (s_sq),
    .q_mis   (s_q_mis),
    .r_mis   (s_r_mis)
  );

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt = ST_ACCUM;
        else       state_nxt = ST_IDLE;
      end
      ST_ACCUM: begin
        if (last_accept_s) state_nxt = ST_DRAIN;
        else               state_nxt = ST_ACCUM;
      end
      ST_DRAIN: begin
        if (drain_cnt_r == 2'(DRAIN_CYCLES - 1)) state_nxt = ST_DONE;
        else                                     state_nxt = ST_DRAIN;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and status flags are registered from the next state so they
  // line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      drain_cnt_r <= 2'd0;
      n_log2_r    <= 4'd0;
      acc_cnt_r   <= {CW{1'b0}};
    end else begin
      state_r     <= state_nxt;
      in_ready_r  <= (state_nxt == ST_ACCUM);
      busy_r      <= (state_nxt == ST_ACCUM) || (state_nxt == ST_DRAIN);
      done_r      <= (state_nxt == ST_DONE);
      drain_cnt_r <= (state_r == ST_DRAIN) ? (drain_cnt_r + 2'd1) : 2'd0;
      if (start_ok_s) begin
        n_log2_r  <= log2_clamped_s;
        acc_cnt_r <= {CW{1'b0}};
      end else if (accept_s) begin
        acc_cnt_r <= acc_cnt_r + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start_ok_s) begin
      sse_r       <= {SSE_W{1'b0}};
      sat_r       <= 1'b0;
      max_err_r   <= {Q_W{1'b0}};
      q_mis_cnt_r <= {CNT_W{1'b0}};
      r_mis_cnt_r <= {CNT_W{1'b0}};
    end else if (s_vld) begin
      sse_r <= SSE_W'(sat_add(64'(sse_r), 64'(s_sq), SSE_W));
      if (sat_ovf(64'(sse_r), 64'(s_sq), SSE_W)) sat_r <= 1'b1;
      if (s_abs > max_err_r) max_err_r <= s_abs;
      if (s_q_mis) q_mis_cnt_r <= CNT_W'(sat_add(64'(q_mis_cnt_r), 64'd1, CNT_W));
      if (s_r_mis) r_mis_cnt_r <= CNT_W'(sat_add(64'(r_mis_cnt_r), 64'd1, CNT_W));
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign sse       = sse_r;
  assign mse       = sse_r >> n_log2_r;
  assign max_err   = max_err_r;
  assign q_mis_cnt = q_mis_cnt_r;
  assign r_mis_cnt = r_mis_cnt_r;
  assign sat       = sat_r;

endmodule

// File: tb/tb_div_err_accumulator.sv
// Randomised and directed bench for div_err_accumulator; two instances
// (32-bit and 16-bit SSE) share stimulus and are checked against one model.
module tb_div_err_accumulator;

  localparam int P_IDLE = 0, P_ACC = 1, P_DRAIN = 2, P_DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, in_valid;
  logic [3:0] win_log2;
  logic [7:0] q_apx, q_ext, r_apx, r_ext;

  logic        in_ready, busy, done, sat;
  logic [31:0] sse, mse;
  logic [7:0]  max_err;
  logic [15:0] q_mis_cnt, r_mis_cnt;

  logic        b_in_ready, b_busy, b_done, b_sat;
  logic [15:0] b_sse, b_mse;
  logic [7:0]  b_max_err;
  logic [15:0] b_q_mis_cnt, b_r_mis_cnt;

  div_err_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_log2(win_log2),
    .in_valid(in_valid), .in_ready(in_ready),
    .q_apx(q_apx), .q_ext(q_ext), .r_apx(r_apx), .r_ext(r_ext),
    .busy(busy), .done(done), .sse(sse), .mse(mse), .max_err(max_err),
    .q_mis_cnt(q_mis_cnt), .r_mis_cnt(r_mis_cnt), .sat(sat)
  );

  div_err_accumulator #(.SSE_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .win_log2(win_log2),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .q_apx(q_apx), .q_ext(q_ext), .r_apx(r_apx), .r_ext(r_ext),
    .busy(b_busy), .done(b_done), .sse(b_sse), .mse(b_mse), .max_err(b_max_err),
    .q_mis_cnt(b_q_mis_cnt), .r_mis_cnt(b_r_mis_cnt), .sat(b_sat)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  bit chk_en = 1'b0;
  bit noise = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase, accepted samples, and window results.
  int m_ph = P_IDLE;
  int m_n, m_log2, m_cnt, m_dly;
  int qa_q[$], qe_q[$], rm_q[$];
  longint e_sse, e_mse, e_sse16, e_mse16, e_max, e_qm, e_rm;
  bit e_sat, e_sat16;

  task automatic clear_exp();
    e_sse = 0; e_mse = 0; e_sse16 = 0; e_mse16 = 0;
    e_max = 0; e_qm = 0; e_rm = 0; e_sat = 0; e_sat16 = 0;
  endtask

  task automatic compute_exp();
    longint s, e;
    s = 0; e_max = 0; e_qm = 0; e_rm = 0;
    foreach (qa_q[i]) begin
      e = (qa_q[i] > qe_q[i]) ? qa_q[i] - qe_q[i] : qe_q[i] - qa_q[i];
      s += e * e;
      if (e > e_max) e_max = e;
      if (e != 0) e_qm++;
      e_rm += rm_q[i];
    end
    e_sat   = (s > 64'hFFFF_FFFF);
    e_sse   = e_sat ? 64'hFFFF_FFFF : s;
    e_sat16 = (s > 64'hFFFF);
    e_sse16 = e_sat16 ? 64'hFFFF : s;
    if (e_qm > 65535) e_qm = 65535;
    if (e_rm > 65535) e_rm = 65535;
    e_mse   = e_sse >> m_log2;
    e_mse16 = e_sse16 >> m_log2;
  endtask

  initial begin
    clear_exp();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_ph = P_IDLE; m_cnt = 0; clear_exp();
      end else begin
        case (m_ph)
          P_IDLE: if (start) begin
            m_log2 = (win_log2 > 15) ? 15 : int'(win_log2);
            m_n = 1 << m_log2;
            qa_q.delete(); qe_q.delete(); rm_q.delete();
            m_cnt = 0; m_ph = P_ACC;
          end
          P_ACC: if (in_valid) begin
            qa_q.push_back(int'(q_apx)); qe_q.push_back(int'(q_ext));
            rm_q.push_back((r_apx != r_ext) ? 1 : 0);
            m_cnt++;
            if (m_cnt == m_n) begin m_ph = P_DRAIN; m_dly = 2; end
          end
          P_DRAIN: begin
            m_dly--;
            if (m_dly == 0) begin m_ph = P_DONE; compute_exp(); end
          end
          default: m_ph = P_IDLE;
        endcase
      end
    end
  end

  // Compare process: handshake every cycle, results whenever not busy.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("in_ready", in_ready, m_ph == P_ACC);
        check("busy", busy, (m_ph == P_ACC) || (m_ph == P_DRAIN));
        check("done", done, m_ph == P_DONE);
        check("b_in_ready", b_in_ready, m_ph == P_ACC);
        check("b_busy", b_busy, (m_ph == P_ACC) || (m_ph == P_DRAIN));
        check("b_done", b_done, m_ph == P_DONE);
        if (m_ph == P_IDLE || m_ph == P_DONE) begin
          check("sse", sse, e_sse);
          check("mse", mse, e_mse);
          check("sat", sat, e_sat);
          check("max_err", max_err, e_max);
          check("q_mis_cnt", q_mis_cnt, e_qm);
          check("r_mis_cnt", r_mis_cnt, e_rm);
          check("b_sse", b_sse, e_sse16);
          check("b_mse", b_mse, e_mse16);
          check("b_sat", b_sat, e_sat16);
          check("b_max_err", b_max_err, e_max);
          check("b_q_mis_cnt", b_q_mis_cnt, e_qm);
          check("b_r_mis_cnt", b_r_mis_cnt, e_rm);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done) n_done++;
  end

  task automatic start_win(input logic [3:0] wl);
    start = 1'b1; win_log2 = wl;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] qa, input logic [7:0] qe,
                      input logic [7:0] ra, input logic [7:0] re);
    int gap;
    bit got;
    gap = noise ? $urandom_range(0, 3) : $urandom_range(0, 1);
    repeat (gap) begin
      in_valid = 1'b0;
      q_apx = 8'($urandom); q_ext = 8'($urandom);
      if (noise && ($urandom_range(0, 2) == 0)) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b1; q_apx = qa; q_ext = qe; r_apx = ra; r_ext = re;
    got = 1'b0;
    for (int t = 0; t < 64 && !got; t++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
    end
    if (!got) check("feed_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit poke, output int k);
    bit found;
    k = 0; found = 1'b0;
    while (!found && k < budget) begin
      @(negedge clk);
      k++;
      found = done;
    end
    if (!found) check("done_timeout", 64'd0, 64'd1);
    if (poke) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int k, d0, nd, wl;
    logic [7:0] qa, qe, ra, re;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; win_log2 = 4'd0;
    q_apx = 8'd0; q_ext = 8'd0; r_apx = 8'd0; r_ext = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_in_ready", in_ready, 64'd0);
    check("rst_sse", sse, 64'd0);
    check("rst_sat", sat, 64'd0);
    rst_n = 1'b1;

    // Mid-window reset abandons the window.
    start_win(4'd4);
    repeat (5) feed(8'd9, 8'd3, 8'd1, 8'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    d0 = n_done;
    repeat (20) @(posedge clk);
    #1;
    check("rst_no_done", n_done - d0, 64'd0);
    check("rst_busy", busy, 64'd0);
    check("rst_qmis", q_mis_cnt, 64'd0);

    // Exact match window and done latency.
    start_win(4'd3);
    repeat (8) feed(8'h2A, 8'h2A, 8'h05, 8'h05);
    wait_done(20, 1'b0, k);
    check("exact_latency", k, 64'd3);
    check("exact_sse", sse, 64'd0);
    check("exact_max", max_err, 64'd0);
    check("exact_qmis", q_mis_cnt, 64'd0);

    // Mixed errors.
    start_win(4'd2);
    feed(8'd10, 8'd7, 8'd0, 8'd0);
    feed(8'd7, 8'd10, 8'd0, 8'd0);
    feed(8'd0, 8'd0, 8'd0, 8'd0);
    feed(8'd255, 8'd0, 8'd0, 8'd0);
    wait_done(20, 1'b0, k);
    check("mixed_sse", sse, 64'd65043);
    check("mixed_mse", mse, 64'd16260);
    check("mixed_max", max_err, 64'd255);
    check("mixed_qmis", q_mis_cnt, 64'd3);
    check("mixed_rmis", r_mis_cnt, 64'd0);

    // Gaps, stray starts, in_ready drop after the last accept.
    noise = 1'b1;
    start_win(4'd1);
    feed(8'd5, 8'd3, 8'd1, 8'd1);
    feed(8'd9, 8'd9, 8'd1, 8'd4);
    check("ready_drop", in_ready, 64'd0);
    in_valid = 1'b1; q_apx = 8'd200; q_ext = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; start = 1'b0;
    wait_done(20, 1'b1, k);
    check("gap_sse", sse, 64'd4);
    check("gap_qmis", q_mis_cnt, 64'd1);
    check("gap_rmis", r_mis_cnt, 64'd1);
    check("gap_max", max_err, 64'd2);

    // Saturation of the 16-bit build.
    start_win(4'd2);
    repeat (4) feed(8'd255, 8'd0, 8'd0, 8'd0);
    wait_done(20, 1'b0, k);
    check("sat16_sse", b_sse, 64'hFFFF);
    check("sat16_flag", b_sat, 64'd1);
    check("sat16_mse", b_mse, 64'd16383);
    check("sat32_sse", sse, 64'd260100);
    check("sat32_flag", sat, 64'd0);

    // Randomised windows.
    for (int w = 0; w < 8; w++) begin
      wl = $urandom_range(0, 5);
      start_win(4'(wl));
      for (int i = 0; i < (1 << wl); i++) begin
        qa = 8'($urandom);
        qe = ($urandom_range(0, 1) == 0) ? qa : 8'($urandom);
        ra = 8'($urandom);
        re = ($urandom_range(0, 1) == 0) ? ra : 8'($urandom);
        feed(qa, qe, ra, re);
      end
      wait_done(20, 1'($urandom_range(0, 1)), k);
    end
    noise = 1'b0;

    // Largest window, remainder mismatch on every 4th sample.
    start_win(4'd15);
    in_valid = 1'b1;
    for (int i = 0; i < 32768; i++) begin
      q_apx = 8'($urandom); q_ext = 8'($urandom);
      r_apx = 8'($urandom);
      r_ext = ((i % 4) == 3) ? (r_apx ^ 8'h01) : r_apx;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    d0 = n_done;
    wait_done(20, 1'b0, k);
    repeat (10) @(posedge clk);
    #1;
    nd = n_done - d0;
    check("clamp_rmis", r_mis_cnt, 64'd8192);
    check("clamp_done_once", nd, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
